// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset control unit
// Moore FSM plus instruction decode, condition check and NZCV flags register.
module mc_controller #(
   parameter int ALUCTRL_W     = 3,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [19:0]          Instr,
   input  logic [3:0]           ALUFlags,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic [1:0]           ResultSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           RegSrc,
   output logic [1:0]           ImmSrc,
   output logic                 RegWrite,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic [3:0]           State
);

   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
      S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
      S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_UNKNOWN = 4'd10
   } state_t;

   state_t      state;
   logic [3:0]  flags;

   logic [3:0]  cond;
   logic [1:0]  op;
   logic        ibit;
   logic [3:0]  cmd;
   logic        sbit;
   logic [3:0]  rd;
   logic        unused_rn;

   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign ibit      = Instr[13];
   assign cmd       = Instr[12:9];
   assign sbit      = Instr[8];
   assign unused_rn = ^Instr[7:4];
   assign rd        = Instr[3:0];

   logic [2:0]  alu_code;
   logic        no_write;
   logic        arith;
   logic [1:0]  flag_w;
   logic        cond_ex;
   logic        mem_ok;
   logic        rd_not_pc;

   always_comb begin
      alu_code = 3'd0;
      no_write = 1'b0;
      arith    = 1'b0;
      case (cmd)
         4'b0100: begin alu_code = 3'd0; arith = 1'b1; end
         4'b0010: begin alu_code = 3'd1; arith = 1'b1; end
         4'b0000: alu_code = 3'd2;
         4'b1100: alu_code = 3'd3;
         4'b0001: alu_code = 3'd4;
         4'b1010: begin alu_code = 3'd1; arith = 1'b1; no_write = 1'b1; end
         default: begin alu_code = 3'd0; no_write = 1'b1; end
      endcase
   end

   assign flag_w = {sbit, sbit & arith};

   // flags = {N,Z,C,V}
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flags[2];
         4'b0001: cond_ex = ~flags[2];
         4'b0010: cond_ex = flags[1];
         4'b0011: cond_ex = ~flags[1];
         4'b0100: cond_ex = flags[3];
         4'b0101: cond_ex = ~flags[3];
         4'b0110: cond_ex = flags[0];
         4'b0111: cond_ex = ~flags[0];
         4'b1000: cond_ex = flags[1] & ~flags[2];
         4'b1001: cond_ex = ~flags[1] | flags[2];
         4'b1010: cond_ex = (flags[3] == flags[0]);
         4'b1011: cond_ex = (flags[3] != flags[0]);
         4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
         4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   assign mem_ok    = MEM_HANDSHAKE ? MemReady : 1'b1;
   assign rd_not_pc = (rd != 4'd15);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         flags <= 4'b0000;
      end else begin
         case (state)
            S_FETCH:  state <= mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (op)
                  2'b00:   state <= ibit ? S_EXECI : S_EXECR;
                  2'b01:   state <= S_MEMADR;
                  2'b10:   state <= S_BRANCH;
                  default: state <= S_UNKNOWN;
               endcase
            end
            S_MEMADR: state <= sbit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state <= mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state <= mem_ok ? S_FETCH : S_MEMWR;
            S_EXECR,
            S_EXECI:  state <= S_ALUWB;
            default:  state <= S_FETCH;
         endcase
         if (state == S_ALUWB && cond_ex) begin
            if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
            if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   assign State  = state;
   assign RegSrc = {op == 2'b01, op == 2'b10};
   assign ImmSrc = op;

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      RegWrite   = 1'b0;
      ALUControl = '0;
      case (state)
         S_FETCH: begin
            IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            PCWrite = mem_ok;
         end
         S_DECODE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         end
         S_MEMADR: ALUSrcB = 2'b01;
         S_MEMRD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01; RegWrite = cond_ex & rd_not_pc;
         end
         S_MEMWR: begin
            AdrSrc = 1'b1; MemWrite = cond_ex;
         end
         S_EXECR: ALUControl = ALUCTRL_W'(alu_code);
         S_EXECI: begin
            ALUSrcB = 2'b01; ALUControl = ALUCTRL_W'(alu_code);
         end
         S_ALUWB:  RegWrite = cond_ex & ~no_write & rd_not_pc;
         S_BRANCH: begin
            ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = cond_ex;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

   logic        clk;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
   logic [1:0]  ResultSrc, ALUSrcB, RegSrc, ImmSrc;
   logic [2:0]  ALUControl;
   logic [3:0]  State;

   int pass_cnt  = 0;
   int total_cnt = 0;

   mc_controller #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1'b1)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegSrc(RegSrc),
      .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl), .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] w);
      Instr = w[31:12];
   endtask

   task automatic test_reset();
      tick();
      total_cnt++; if (State !== 4'd0) $display("FAIL reset_state got=%0d exp=0", State); else pass_cnt++;
      total_cnt++; if (IRWrite !== 1'b1) $display("FAIL reset_irwrite got=%b exp=1", IRWrite); else pass_cnt++;
      total_cnt++; if (PCWrite !== 1'b1) $display("FAIL reset_pcwrite got=%b exp=1", PCWrite); else pass_cnt++;
      total_cnt++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 5'b1_10_10) $display("FAIL reset_fetch_muxes got=%b exp=11010", {ALUSrcA, ALUSrcB, ResultSrc}); else pass_cnt++;
      total_cnt++; if ({RegWrite, MemWrite, AdrSrc} !== 3'b000) $display("FAIL reset_writes got=%b exp=000", {RegWrite, MemWrite, AdrSrc}); else pass_cnt++;
      MemReady = 1'b0;
      #1;
      total_cnt++; if (PCWrite !== 1'b0) $display("FAIL reset_pcwrite_memready got=%b exp=0", PCWrite); else pass_cnt++;
      MemReady = 1'b1;
      reset = 1'b0;
   endtask

   task automatic test_add();
      set_instr(32'hE0810002);
      #1;
      total_cnt++; if (State !== 4'd0) $display("FAIL add_fetch got=%0d exp=0", State); else pass_cnt++;
      tick();
      total_cnt++; if (State !== 4'd1) $display("FAIL add_decode got=%0d exp=1", State); else pass_cnt++;
      tick();
      total_cnt++; if (State !== 4'd6) $display("FAIL add_execr got=%0d exp=6", State); else pass_cnt++;
      total_cnt++; if (ALUControl !== 3'd0) $display("FAIL add_aluctl got=%0d exp=0", ALUControl); else pass_cnt++;
      tick();
      total_cnt++; if (State !== 4'd8) $display("FAIL add_aluwb got=%0d exp=8", State); else pass_cnt++;
      total_cnt++; if (RegWrite !== 1'b1) $display("FAIL add_regwrite got=%b exp=1", RegWrite); else pass_cnt++;
      tick();
      total_cnt++; if (State !== 4'd0) $display("FAIL add_return got=%0d exp=0", State); else pass_cnt++;
   endtask

   task automatic test_cmp_beq();
      set_instr(32'hE3510005);
      tick(); tick();
      total_cnt++; if (State !== 4'd7) $display("FAIL cmp_execi got=%0d exp=7", State); else pass_cnt++;
      total_cnt++; if ({ALUControl, ALUSrcB} !== 5'b001_01) $display("FAIL cmp_execi_ctl got=%b exp=00101", {ALUControl, ALUSrcB}); else pass_cnt++;
      tick();
      ALUFlags = 4'b0100;
      #1;
      total_cnt++; if (RegWrite !== 1'b0) $display("FAIL cmp_regwrite got=%b exp=0", RegWrite); else pass_cnt++;
      tick();
      ALUFlags = 4'b0000;
      set_instr(32'h0A000001);
      #1;
      total_cnt++; if ({RegSrc, ImmSrc} !== 4'b01_10) $display("FAIL beq_regsrc_immsrc got=%b exp=0110", {RegSrc, ImmSrc}); else pass_cnt++;
      tick(); tick();
      total_cnt++; if (State !== 4'd9) $display("FAIL beq_branch got=%0d exp=9", State); else pass_cnt++;
      total_cnt++; if (PCWrite !== 1'b1) $display("FAIL beq_taken got=%b exp=1", PCWrite); else pass_cnt++;
      tick();
      set_instr(32'h1A000001);
      tick(); tick();
      total_cnt++; if (PCWrite !== 1'b0) $display("FAIL bne_not_taken got=%b exp=0", PCWrite); else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid();
      set_instr(32'hE5912004);
      tick(); tick(); tick();
      total_cnt++; if (State !== 4'd3) $display("FAIL rst_mid_memrd got=%0d exp=3", State); else pass_cnt++;
      MemReady = 1'b0;
      reset = 1'b1;
      #1;
      total_cnt++; if (State !== 4'd0) $display("FAIL rst_mid_state got=%0d exp=0", State); else pass_cnt++;
      total_cnt++; if (IRWrite !== 1'b1) $display("FAIL rst_mid_irwrite got=%b exp=1", IRWrite); else pass_cnt++;
      total_cnt++; if ({RegWrite, MemWrite} !== 2'b00) $display("FAIL rst_mid_writes got=%b exp=00", {RegWrite, MemWrite}); else pass_cnt++;
      tick();
      reset = 1'b0;
      MemReady = 1'b1;
      set_instr(32'h0A000001);
      tick(); tick();
      total_cnt++; if (State !== 4'd9) $display("FAIL rst_flags_branch got=%0d exp=9", State); else pass_cnt++;
      total_cnt++; if (PCWrite !== 1'b0) $display("FAIL rst_flags_cleared got=%b exp=0", PCWrite); else pass_cnt++;
      tick();
   endtask

   task automatic test_ldr_wait();
      set_instr(32'hE5912004);
      MemReady = 1'b0;
      #1;
      total_cnt++; if (PCWrite !== 1'b0) $display("FAIL fetch_wait_pcwrite got=%b exp=0", PCWrite); else pass_cnt++;
      tick();
      total_cnt++; if (State !== 4'd0) $display("FAIL fetch_wait_hold got=%0d exp=0", State); else pass_cnt++;
      MemReady = 1'b1;
      tick(); tick();
      total_cnt++; if ({State, ALUSrcB} !== 6'b0010_01) $display("FAIL ldr_memadr got=%b exp=001001", {State, ALUSrcB}); else pass_cnt++;
      tick();
      total_cnt++; if ({State, AdrSrc} !== 5'b0011_1) $display("FAIL ldr_memrd got=%b exp=00111", {State, AdrSrc}); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         MemReady = 1'b0;
         tick();
         total_cnt++; if (State !== 4'd3) $display("FAIL ldr_wait_%0d got=%0d exp=3", i, State); else pass_cnt++;
      end
      MemReady = 1'b1;
      tick();
      total_cnt++; if (State !== 4'd4) $display("FAIL ldr_memwb got=%0d exp=4", State); else pass_cnt++;
      total_cnt++; if ({RegWrite, ResultSrc} !== 3'b1_01) $display("FAIL ldr_writeback got=%b exp=101", {RegWrite, ResultSrc}); else pass_cnt++;
      tick();
      total_cnt++; if (State !== 4'd0) $display("FAIL ldr_return got=%0d exp=0", State); else pass_cnt++;
   endtask

   task automatic test_store();
      set_instr(32'hE3510005);
      tick(); tick(); tick();
      ALUFlags = 4'b0100;
      tick();
      ALUFlags = 4'b0000;
      set_instr(32'h15812000);
      tick(); tick(); tick();
      total_cnt++; if (State !== 4'd5) $display("FAIL strne_memwr got=%0d exp=5", State); else pass_cnt++;
      total_cnt++; if ({MemWrite, AdrSrc, RegSrc} !== 4'b0_1_10) $display("FAIL strne_outputs got=%b exp=0110", {MemWrite, AdrSrc, RegSrc}); else pass_cnt++;
      tick();
      total_cnt++; if (State !== 4'd0) $display("FAIL strne_return got=%0d exp=0", State); else pass_cnt++;
      set_instr(32'hE5812000);
      tick(); tick(); tick();
      MemReady = 1'b0;
      #1;
      total_cnt++; if (MemWrite !== 1'b1) $display("FAIL str_memwrite got=%b exp=1", MemWrite); else pass_cnt++;
      tick();
      total_cnt++; if ({State, MemWrite} !== 5'b0101_1) $display("FAIL str_hold got=%b exp=01011", {State, MemWrite}); else pass_cnt++;
      MemReady = 1'b1;
      tick();
      total_cnt++; if (State !== 4'd0) $display("FAIL str_return got=%0d exp=0", State); else pass_cnt++;
   endtask

   task automatic test_cond_unknown();
      set_instr(32'hF0810002);
      tick(); tick(); tick();
      total_cnt++; if ({State, RegWrite} !== 5'b1000_0) $display("FAIL nv_aluwb got=%b exp=10000", {State, RegWrite}); else pass_cnt++;
      tick();
      set_instr(32'hEC000000);
      tick(); tick();
      total_cnt++; if (State !== 4'd10) $display("FAIL unknown_state got=%0d exp=10", State); else pass_cnt++;
      total_cnt++; if ({PCWrite, RegWrite, MemWrite, IRWrite} !== 4'b0000) $display("FAIL unknown_writes got=%b exp=0000", {PCWrite, RegWrite, MemWrite, IRWrite}); else pass_cnt++;
      tick();
      total_cnt++; if (State !== 4'd0) $display("FAIL unknown_return got=%0d exp=0", State); else pass_cnt++;
   endtask

   task automatic test_alu_decode();
      logic [31:0] words [6] = '{32'hE0410002, 32'hE0010002, 32'hE1810002,
                                 32'hE0210002, 32'hE1A10002, 32'hE081F002};
      logic [2:0]  ctl   [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
      logic        rw    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         set_instr(words[i]);
         tick(); tick();
         total_cnt++; if (ALUControl !== ctl[i]) $display("FAIL decode_aluctl_%0d got=%0d exp=%0d", i, ALUControl, ctl[i]); else pass_cnt++;
         tick();
         total_cnt++; if (RegWrite !== rw[i]) $display("FAIL decode_regwrite_%0d got=%b exp=%b", i, RegWrite, rw[i]); else pass_cnt++;
         tick();
      end
   endtask

   initial begin
      reset    = 1'b1;
      MemReady = 1'b1;
      ALUFlags = 4'b0000;
      Instr    = 20'h0;
      test_reset();
      test_add();
      test_cmp_beq();
      test_reset_mid();
      test_ldr_wait();
      test_store();
      test_cond_unknown();
      test_alu_decode();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
